// File: rtl/pc_alu_cmp_pkg.sv
// Shared constants for the execute/fetch-control slice: datapath width,
// ALU operation codes and comparator (jump) codes. The decoder imports
// this same package so both sides agree on the encodings.
package pc_alu_cmp_pkg;

    localparam int XLEN  = 16;
    localparam int ALU_W = 4;
    localparam int JMP_W = 3;

    // ALU operation select codes (12..15 are unused and yield zero)
    localparam logic [ALU_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_W-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_W-1:0] ALU_NOT   = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SHL   = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SHR   = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SRA   = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SLT   = 4'd9;
    localparam logic [ALU_W-1:0] ALU_SLTU  = 4'd10;
    localparam logic [ALU_W-1:0] ALU_PASSB = 4'd11;

    // Comparator select codes
    localparam logic [JMP_W-1:0] JMP_NONE   = 3'd0;
    localparam logic [JMP_W-1:0] JMP_BEQ    = 3'd1;
    localparam logic [JMP_W-1:0] JMP_BNE    = 3'd2;
    localparam logic [JMP_W-1:0] JMP_BLT    = 3'd3;
    localparam logic [JMP_W-1:0] JMP_BGE    = 3'd4;
    localparam logic [JMP_W-1:0] JMP_BLTU   = 3'd5;
    localparam logic [JMP_W-1:0] JMP_BGEU   = 3'd6;
    localparam logic [JMP_W-1:0] JMP_ALWAYS = 3'd7;

endpackage

// File: rtl/pc_alu_cmp_alu.sv
// Purely combinational 16-bit ALU. The shift operations (codes 6..8) are
// only built when PC_ALU_CMP_SHIFT_EN is defined; otherwise those codes
// return zero and no shifter exists in the netlist.
module pc_alu_cmp_alu
    import pc_alu_cmp_pkg::*;
(
    input  logic [ALU_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    // Select the operation result; unused codes fall through to zero
    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOT:   result = ~a;
`ifdef PC_ALU_CMP_SHIFT_EN
            ALU_SHL:   result = a << b[3:0];
            ALU_SHR:   result = a >> b[3:0];
            ALU_SRA:   result = a_s >>> b[3:0];
`else
            ALU_SHL:   result = '0;
            ALU_SHR:   result = '0;
            ALU_SRA:   result = '0;
`endif
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/pc_alu_cmp.sv
// Execute and fetch-control slice of the 16-bit single-cycle CPU: program
// counter, ALU and branch comparator. The PC either steps by one word or
// loads the absolute target (imm_se) when the comparator fires, giving a
// single-cycle branch with no delay slot.
// Optional feature macro: PC_ALU_CMP_SHIFT_EN (enables ALU shift codes 6..8).
module pc_alu_cmp
    import pc_alu_cmp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] alu_ctrl,
    input  logic [JMP_W-1:0] jump_ctrl,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic [XLEN-1:0]  imm_se,
    input  logic             alu_src_imm,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  alu_result,
    output logic             alu_zero,
    output logic             branch_taken,
    output logic [XLEN-1:0]  pc_jump_addr
);

    logic [XLEN-1:0]        alu_b;
    logic [XLEN-1:0]        pc_next;
    logic signed [XLEN-1:0] cmp_a_s;
    logic signed [XLEN-1:0] cmp_b_s;

    assign alu_b        = alu_src_imm ? imm_se : operand_b;
    assign alu_zero     = (alu_result == '0);
    assign pc_jump_addr = imm_se;

    pc_alu_cmp_alu u_alu (
        .alu_ctrl (alu_ctrl),
        .a        (operand_a),
        .b        (alu_b),
        .result   (alu_result)
    );

    // The comparator always looks at the register operands, never the immediate
    assign cmp_a_s = operand_a;
    assign cmp_b_s = operand_b;

    // Resolve the branch condition for the selected comparison
    always_comb begin
        branch_taken = 1'b0;
        case (jump_ctrl)
            JMP_NONE:   branch_taken = 1'b0;
            JMP_BEQ:    branch_taken = (operand_a == operand_b);
            JMP_BNE:    branch_taken = (operand_a != operand_b);
            JMP_BLT:    branch_taken = (cmp_a_s <  cmp_b_s);
            JMP_BGE:    branch_taken = (cmp_a_s >= cmp_b_s);
            JMP_BLTU:   branch_taken = (operand_a <  operand_b);
            JMP_BGEU:   branch_taken = (operand_a >= operand_b);
            JMP_ALWAYS: branch_taken = 1'b1;
            default:    branch_taken = 1'b0;
        endcase
    end

    // Sequential increment wraps naturally at 0xFFFF
    assign pc_next = branch_taken ? pc_jump_addr : (pc_out + 16'd1);

    // PC register; reset forces zero immediately and overrides any pending branch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out <= '0;
        end else begin
            pc_out <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_alu_cmp.sv
// Self-checking bench for pc_alu_cmp: directed vectors with literal
// expectations plus a behavioural model compared every cycle.
module tb_pc_alu_cmp;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic [2:0]  jump_ctrl;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [15:0] imm_se;
    logic        alu_src_imm;
    logic [15:0] pc_out;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        branch_taken;
    logic [15:0] pc_jump_addr;

    int total = 0;
    int bad   = 0;
    bit run   = 0;
    logic [15:0] exp_pc;

    pc_alu_cmp dut (
        .clk          (clk),
        .rst          (rst),
        .alu_ctrl     (alu_ctrl),
        .jump_ctrl    (jump_ctrl),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .imm_se       (imm_se),
        .alu_src_imm  (alu_src_imm),
        .pc_out       (pc_out),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .branch_taken (branch_taken),
        .pc_jump_addr (pc_jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU from arithmetic rules on integers
    function automatic logic [15:0] m_alu(int op, logic [15:0] a, logic [15:0] b);
        longint ua, ub, d;
        int sa, sb;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        d  = longint'(1) << (ub % 16);
        case (op)
            0:  return 16'((ua + ub) % 65536);
            1:  return 16'((ua - ub + 65536) % 65536);
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return 16'(65535 - ua);
`ifdef PC_ALU_CMP_SHIFT_EN
            6:  return 16'((ua * d) % 65536);
            7:  return 16'(ua / d);
            8:  return 16'((longint'(sa) - (((longint'(sa) % d) + d) % d)) / d);
`endif
            9:  return (sa < sb) ? 16'd1 : 16'd0;
            10: return (ua < ub) ? 16'd1 : 16'd0;
            11: return b;
            default: return 16'd0;
        endcase
    endfunction

    // Reference branch decision
    function automatic bit m_taken(int j, logic [15:0] a, logic [15:0] b);
        int sa, sb, ua, ub;
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        case (j)
            1: return ua == ub;
            2: return ua != ub;
            3: return sa < sb;
            4: return sa >= sb;
            5: return ua < ub;
            6: return ua >= ub;
            7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected PC, tracked alongside the DUT
    always @(posedge clk or negedge rst) begin
        if (!rst) exp_pc <= 16'h0000;
        else exp_pc <= m_taken(jump_ctrl, operand_a, operand_b) ? imm_se : exp_pc + 16'd1;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (run) begin
            logic [15:0] r;
            r = m_alu(alu_ctrl, operand_a, alu_src_imm ? imm_se : operand_b);
            chk("m_pc", pc_out, exp_pc);
            chk("m_alu_result", alu_result, r);
            chk("m_alu_zero", {15'd0, alu_zero}, {15'd0, r == 16'd0});
            chk("m_branch_taken", {15'd0, branch_taken},
                {15'd0, m_taken(jump_ctrl, operand_a, operand_b)});
            chk("m_pc_jump_addr", pc_jump_addr, imm_se);
        end
    end

    // Drive one vector just after a rising edge; returns mid-cycle
    task automatic apply(int op, int jc, logic [15:0] a, logic [15:0] b,
                         logic [15:0] imm, bit src);
        @(posedge clk);
        #1;
        alu_ctrl    = 4'(op);
        jump_ctrl   = 3'(jc);
        operand_a   = a;
        operand_b   = b;
        imm_se      = imm;
        alu_src_imm = src;
        #2;
    endtask

    logic [15:0] va [0:5] = '{16'h0000, 16'h7FFF, 16'h8001, 16'hFFFF, 16'h1234, 16'h0005};
    logic [15:0] vb [0:5] = '{16'h0000, 16'h0001, 16'h0004, 16'hFFFF, 16'h8000, 16'h0005};

    initial begin
        rst = 1'b1;
        alu_ctrl = 4'd0; jump_ctrl = 3'd0;
        operand_a = 16'd0; operand_b = 16'd0; imm_se = 16'd0; alu_src_imm = 1'b0;
        #2 rst = 1'b0;
        #1 chk("reset_async", pc_out, 16'h0000);
        run = 1;
        repeat (2) @(negedge clk);
        chk("reset_held", pc_out, 16'h0000);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("pc_inc3", pc_out, 16'h0003);

        // Arithmetic
        apply(0, 0, 16'h7FFF, 16'h0001, 16'h0000, 0);
        chk("add_ovf", alu_result, 16'h8000);
        chk("add_ovf_zero", {15'd0, alu_zero}, 16'd0);
        apply(1, 0, 16'h0005, 16'h0005, 16'h0000, 0);
        chk("sub_zero", alu_result, 16'h0000);
        chk("sub_zero_flag", {15'd0, alu_zero}, 16'd1);
        apply(0, 0, 16'h0003, 16'h0100, 16'hFFFE, 1);
        chk("add_imm", alu_result, 16'h0001);

        // Signed vs unsigned compare
        apply(9, 3, 16'hFFFF, 16'h0001, 16'h0000, 0);
        chk("slt", alu_result, 16'h0001);
        chk("blt_taken", {15'd0, branch_taken}, 16'd1);
        apply(10, 5, 16'hFFFF, 16'h0001, 16'h0000, 0);
        chk("sltu", alu_result, 16'h0000);
        chk("bltu_not", {15'd0, branch_taken}, 16'd0);

        // Shifts
        apply(6, 0, 16'h8001, 16'h0004, 16'h0000, 0);
`ifdef PC_ALU_CMP_SHIFT_EN
        chk("shl", alu_result, 16'h0010);
        apply(7, 0, 16'h8001, 16'h0004, 16'h0000, 0);
        chk("shr", alu_result, 16'h0800);
        apply(8, 0, 16'h8001, 16'h0004, 16'h0000, 0);
        chk("sra", alu_result, 16'hF800);
`else
        chk("shl_off", alu_result, 16'h0000);
        apply(7, 0, 16'h8001, 16'h0004, 16'h0000, 0);
        chk("shr_off", alu_result, 16'h0000);
        apply(8, 0, 16'h8001, 16'h0004, 16'h0000, 0);
        chk("sra_off", alu_result, 16'h0000);
`endif

        // Branches: reach 0x0010, then BEQ taken to 0x0040
        apply(0, 7, 16'h0001, 16'h0002, 16'h0010, 0);
        apply(0, 1, 16'h0005, 16'h0005, 16'h0040, 1);
        chk("pc_at_10", pc_out, 16'h0010);
        chk("beq_taken", {15'd0, branch_taken}, 16'd1);
        chk("jump_addr", pc_jump_addr, 16'h0040);
        apply(0, 7, 16'h0000, 16'h0000, 16'h0010, 0);
        chk("beq_target", pc_out, 16'h0040);
        apply(0, 2, 16'h0005, 16'h0005, 16'h0040, 0);
        apply(0, 7, 16'h1111, 16'h2222, 16'h0200, 0);
        chk("bne_fallthru", pc_out, 16'h0011);
        apply(0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("jmp_target", pc_out, 16'h0200);

        // Self-loop, then wrap
        apply(0, 7, 16'h0000, 16'h0000, 16'h0201, 0);
        apply(0, 7, 16'h0000, 16'h0000, 16'h0201, 0);
        apply(0, 7, 16'h0000, 16'h0000, 16'hFFFF, 0);
        chk("self_loop", pc_out, 16'h0201);
        apply(0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("pc_ffff", pc_out, 16'hFFFF);
        apply(0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("pc_wrap", pc_out, 16'h0000);

        // Reset mid-cycle with JMP pending
        apply(0, 7, 16'h0000, 16'h0000, 16'h1234, 0);
        rst = 1'b0;
        #1 chk("mid_reset", pc_out, 16'h0000);
        @(posedge clk);
        #1 chk("mid_reset_hold", pc_out, 16'h0000);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk("post_release_jmp", pc_out, 16'h1234);

        // Sweep every ALU and jump code over the operand table
        for (int i = 0; i < 6; i++) begin
            for (int op = 0; op < 16; op++) apply(op, op % 8, va[i], vb[i], vb[(i + 1) % 6], op[0]);
            for (int j = 0; j < 8; j++) apply(j, j, va[i], vb[5 - i], va[i], 1);
        end

        @(negedge clk);
        #1;
        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_alu_cmp.md
# pc_alu_cmp

Execute-and-fetch-control slice of the 16-bit single-cycle CPU. It holds the program counter, evaluates the 16-bit ALU operation selected by the decoder, and resolves branch/jump conditions. On each clock it either advances the PC by one word or loads the branch target. It sits between the decoder/register file and instruction/data memory.

## Interface
- No parameters; data width fixed at 16, ALU control 4 bits, jump control 3 bits.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- alu_ctrl  in  4  ALU operation select.
- jump_ctrl  in  3  comparator operation select (0 = no branch).
- operand_a  in  16  register-file port A data.
- operand_b  in  16  register-file port B data.
- imm_se  in  16  sign-extended immediate; also the absolute branch target.
- alu_src_imm  in  1  1: ALU B = imm_se; 0: ALU B = operand_b.
- pc_out  out  16  current program counter (word address).
- alu_result  out  16  ALU result; also used as memory address.
- alu_zero  out  1  alu_result == 0.
- branch_taken  out  1  condition true and jump_ctrl != 0.
- pc_jump_addr  out  16  branch target (= imm_se).

## Operation
- ALU, combinational; A = operand_a, B = mux(alu_src_imm). Codes:
  - 0 ADD A+B; 1 SUB A−B (mod 2^16, no carry out).
  - 2 AND; 3 OR; 4 XOR; 5 NOT A.
  - 6 SHL A<<B[3:0]; 7 SHR logical; 8 SRA arithmetic.
  - 9 SLT signed (1/0); 10 SLTU unsigned (1/0).
  - 11 PASS B.
  - 12–15 result 0.
- Comparator, combinational, on operand_a and operand_b (never the immediate):
  - 0 none, branch_taken = 0.
  - 1 BEQ; 2 BNE.
  - 3 BLT signed; 4 BGE signed.
  - 5 BLTU; 6 BGEU.
  - 7 JMP unconditional.
- pc_jump_addr = imm_se, always driven regardless of jump_ctrl.
- PC next-state: branch_taken ? pc_jump_addr : pc_out + 1.
  - Increment wraps 0xFFFF → 0x0000.
  - A branch to the current PC value (self-loop) is legal.

## Timing
- rst low: pc_out = 0x0000 immediately, independent of clk. Held while low.
- First rising edge after rst rises updates the PC.
- pc_out updates on the rising edge only. All other outputs are combinational, with zero latency from inputs.
- branch_taken and the target are sampled at the same edge as the PC update. This gives a single-cycle branch with no delay slot.
- Reset asserted mid-cycle overrides any pending branch.

## Configuration
- Macro PC_ALU_CMP_SHIFT_EN.
  - Defined: codes 6–8 perform shifts as above.
  - Undefined: codes 6–8 return 0 and no shifter is synthesized.
- All other behaviour is identical in both builds.

## Structure
- Shared package pc_alu_cmp_pkg holds:
  - ALU opcode constants (ALU_ADD … ALU_PASSB).
  - Jump opcode constants (JMP_NONE … JMP_ALWAYS).
  - Width constants (XLEN = 16).
- The decoder imports the same package.
- One natural sub-module: pc_alu_cmp_alu (pure combinational ALU). The comparator and PC register stay inline in the top.

## Test plan
- Reset and increment:
  - rst low → pc_out = 0x0000 asynchronously.
  - Release, jump_ctrl = 0, 3 clocks → pc_out = 0x0003.
- Arithmetic:
  - A = 0x7FFF, B = 0x0001, ADD → 0x8000, alu_zero = 0.
  - A = 0x0005, B = 0x0005, SUB → 0x0000, alu_zero = 1.
  - alu_src_imm = 1, imm_se = 0xFFFE, A = 3, ADD → 0x0001.
- Signed vs unsigned compare:
  - A = 0xFFFF, B = 0x0001: SLT → 1, SLTU → 0.
  - Same operands: BLT taken, BLTU not taken.
- Shifts (macro defined):
  - A = 0x8001, B = 4: SHL → 0x0010, SHR → 0x0800, SRA → 0xF800.
  - Undefined build: all three → 0.
- Branch:
  - pc_out = 0x0010, BEQ with equal operands, imm_se = 0x0040 → next pc_out = 0x0040.
  - BNE with equal operands → 0x0011.
  - JMP → target regardless of operands.
- Wrap and reset mid-run:
  - pc_out = 0xFFFF, no branch → 0x0000.
  - rst low between edges while JMP is pending → pc_out = 0x0000 and stays 0 until release.
